step_phase_decoder: RTL and testbench

Receive-side counterpart to the stepper drive path. Watches the 4-bit full-step coil pattern that the step drivers emit toward the PmodSTEP and decodes it back into step events, direction and an absolute position count. Also homes the count on the lower limit switch and flags illegal patterns, skipped phases and limit overruns. It sits beside each driver instance in the claw top level and feeds position to control logic and to the verification environment.

---
 rtl/step_pkg.sv | 36 +++
 rtl/step_phase_decoder_if.sv | 32 +++
 rtl/coil_sync_filter.sv | 51 +++++
 rtl/step_phase_decoder.sv | 170 +++++++++++++++++
 tb/tb_step_phase_decoder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/step_pkg.sv
// Shared constants and helpers for the step phase decoder: coil pattern table,
// FSM state encodings and the pattern-to-phase-index lookup.
package step_pkg;

    localparam logic [3:0] PH0 = 4'b1001;
    localparam logic [3:0] PH1 = 4'b1010;
    localparam logic [3:0] PH2 = 4'b0110;
    localparam logic [3:0] PH3 = 4'b0101;
    localparam logic [3:0] OFF = 4'b0000;

    typedef logic [1:0] state_t;

    localparam state_t S_OFF     = 2'd0;
    localparam state_t S_ACQUIRE = 2'd1;
    localparam state_t S_TRACK   = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } phase_t;

    function automatic phase_t phase_index(input logic [3:0] pat);
        phase_t res;
        res.valid = 1'b1;
        res.idx   = 2'd0;
        case (pat)
            PH0:     res.idx = 2'd0;
            PH1:     res.idx = 2'd1;
            PH2:     res.idx = 2'd2;
            PH3:     res.idx = 2'd3;
            default: res.valid = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/step_phase_decoder_if.sv
// Bundle of coil/limit inputs and decoded position/status outputs of one
// step phase decoder. The master side drives coil and limits, the slave decodes.
interface step_phase_decoder_if #(
    parameter int unsigned POS_W = 16
);

    logic [3:0]       coil;
    logic [1:0]       limit_switches;
    logic             clr_err;
    logic [POS_W-1:0] position;
    logic [1:0]       phase;
    logic             dir_fwd;
    logic             step_pulse;
    logic             moving;
    logic [1:0]       at_limit;
    logic             err_illegal;
    logic             err_skip;
    logic             err_overrun;

    modport master (
        output coil, limit_switches, clr_err,
        input  position, phase, dir_fwd, step_pulse, moving, at_limit,
        input  err_illegal, err_skip, err_overrun
    );

    modport slave (
        input  coil, limit_switches, clr_err,
        output position, phase, dir_fwd, step_pulse, moving, at_limit,
        output err_illegal, err_skip, err_overrun
    );

endinterface

// File: rtl/coil_sync_filter.sv
// Two-flop synchronizer followed by a stability filter: a pattern is accepted once
// it has been sampled STABLE_CYCLES times in a row; o_changed strobes on a new one.
module coil_sync_filter #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_pattern,
    output logic             o_changed
);

    localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             w_stable;

    assign w_stable  = (r_cnt == CNT_MAX);
    assign o_changed = w_stable && (r_cand != r_acc);
    assign o_pattern = r_cand;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cand  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            // Any sample differing from the candidate restarts the stability count.
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= CNT_W'(1);
            end else if (!w_stable) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (o_changed) begin
                r_acc <= r_cand;
            end
        end
    end

endmodule

// File: rtl/step_phase_decoder.sv
// Decodes full-step coil patterns back into step events, direction and an absolute
// position, with limit homing and sticky illegal/skip/overrun flags.
module step_phase_decoder
    import step_pkg::*;
#(
    parameter int unsigned POS_W         = 16,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned IDLE_CYCLES   = 1_000_000
) (
    input logic              i_clk,
    input logic              i_rst_n,
    step_phase_decoder_if.slave bus
);

    localparam int unsigned      IDLE_W   = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES - 1);

    logic [3:0]        w_pattern;
    logic              w_changed;
    phase_t            w_ph;
    logic [1:0]        w_delta;

    state_t            r_state;
    state_t            w_state_d;
    logic              r_have_phase;
    logic              w_have_d;
    logic [1:0]        r_phase;
    logic [1:0]        w_phase_d;
    logic              r_dir_fwd;
    logic              w_fwd;
    logic              w_step;
    logic              w_set_illegal;
    logic              w_set_skip;
    logic              w_set_overrun;

    logic [POS_W-1:0]  r_position;
    logic              r_step_pulse;
    logic              r_moving;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [1:0]        r_lim_sync1;
    logic [1:0]        r_lim_sync2;
    logic              r_err_illegal;
    logic              r_err_skip;
    logic              r_err_overrun;

    coil_sync_filter #(
        .WIDTH         (4),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_coil_filter (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_async   (bus.coil),
        .o_pattern (w_pattern),
        .o_changed (w_changed)
    );

    assign w_ph    = phase_index(w_pattern);
    assign w_delta = w_ph.idx - r_phase;

    // r_have_phase blocks counting until a valid phase has been loaded as reference,
    // so a reset or an illegal excursion from OFF never yields a spurious step.
    always_comb begin
        w_state_d     = r_state;
        w_have_d      = r_have_phase;
        w_phase_d     = r_phase;
        w_fwd         = r_dir_fwd;
        w_step        = 1'b0;
        w_set_illegal = 1'b0;
        w_set_skip    = 1'b0;
        if (w_changed) begin
            if (w_pattern == OFF) begin
                w_state_d = S_OFF;
                w_have_d  = 1'b0;
            end else if (!w_ph.valid) begin
                w_set_illegal = 1'b1;
                w_state_d     = S_ACQUIRE;
            end else if ((r_state == S_OFF) || !r_have_phase) begin
                w_phase_d = w_ph.idx;
                w_have_d  = 1'b1;
                w_state_d = S_ACQUIRE;
            end else begin
                case (w_delta)
                    2'd1: begin
                        w_step    = 1'b1;
                        w_fwd     = 1'b1;
                        w_phase_d = w_ph.idx;
                        w_state_d = S_TRACK;
                    end
                    2'd3: begin
                        w_step    = 1'b1;
                        w_fwd     = 1'b0;
                        w_phase_d = w_ph.idx;
                        w_state_d = S_TRACK;
                    end
                    2'd2: begin
                        w_set_skip = 1'b1;
                        w_phase_d  = w_ph.idx;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_set_overrun = w_step && ((!w_fwd && r_lim_sync2[0]) || (w_fwd && r_lim_sync2[1]));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_OFF;
            r_have_phase  <= 1'b0;
            r_phase       <= 2'd0;
            r_dir_fwd     <= 1'b0;
            r_step_pulse  <= 1'b0;
            r_position    <= '0;
            r_lim_sync1   <= 2'b00;
            r_lim_sync2   <= 2'b00;
            r_err_illegal <= 1'b0;
            r_err_skip    <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_have_phase  <= w_have_d;
            r_phase       <= w_phase_d;
            r_dir_fwd     <= w_fwd;
            r_step_pulse  <= w_step;
            r_lim_sync1   <= bus.limit_switches;
            r_lim_sync2   <= r_lim_sync1;
            if (r_lim_sync2[0]) begin
                r_position <= '0;
            end else if (w_step) begin
                r_position <= w_fwd ? r_position + POS_W'(1) : r_position - POS_W'(1);
            end
            // A new error event wins over a simultaneous clear.
            r_err_illegal <= w_set_illegal || (r_err_illegal && !bus.clr_err);
            r_err_skip    <= w_set_skip    || (r_err_skip    && !bus.clr_err);
            r_err_overrun <= w_set_overrun || (r_err_overrun && !bus.clr_err);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_moving   <= 1'b0;
            r_idle_cnt <= '0;
        end else if ((w_state_d == S_OFF) && (r_state != S_OFF)) begin
            r_moving   <= 1'b0;
            r_idle_cnt <= '0;
        end else if (w_step) begin
            r_moving   <= 1'b1;
            r_idle_cnt <= '0;
        end else if (r_moving) begin
            if (r_idle_cnt == IDLE_MAX) begin
                r_moving   <= 1'b0;
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end
        end
    end

    assign bus.position    = r_position;
    assign bus.phase       = r_phase;
    assign bus.dir_fwd     = r_dir_fwd;
    assign bus.step_pulse  = r_step_pulse;
    assign bus.moving      = r_moving;
    assign bus.at_limit    = r_lim_sync2;
    assign bus.err_illegal = r_err_illegal;
    assign bus.err_skip    = r_err_skip;
    assign bus.err_overrun = r_err_overrun;

endmodule

// File: tb/tb_step_phase_decoder.sv
// Directed bench for step_phase_decoder: stepping, homing, errors, glitches, idle timeout.
module tb_step_phase_decoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   pulses = 0;
    int   p0     = 0;

    step_phase_decoder_if #(.POS_W(16)) bus ();

    step_phase_decoder #(
        .POS_W         (16),
        .STABLE_CYCLES (4),
        .IDLE_CYCLES   (50)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.step_pulse === 1'b1) pulses = pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] pat, input int n);
        bus.coil = pat;
        tick(n);
    endtask

    task automatic clear_errors();
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
    endtask

    initial begin
        bus.coil           = 4'b0000;
        bus.limit_switches = 2'b00;
        bus.clr_err        = 1'b0;
        tick(3);
        check("rst_position", 32'(bus.position), 32'h0);
        check("rst_phase", 32'(bus.phase), 32'h0);
        check("rst_dir", 32'(bus.dir_fwd), 32'h0);
        check("rst_step", 32'(bus.step_pulse), 32'h0);
        check("rst_moving", 32'(bus.moving), 32'h0);
        check("rst_at_limit", 32'(bus.at_limit), 32'h0);
        check("rst_err_illegal", 32'(bus.err_illegal), 32'h0);
        check("rst_err_skip", 32'(bus.err_skip), 32'h0);
        check("rst_err_overrun", 32'(bus.err_overrun), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Forward stepping; first phase after reset only acquires
        p0 = pulses;
        hold(4'b1001, 20);
        check("acquire_no_step", 32'(pulses - p0), 32'd0);
        check("acquire_pos", 32'(bus.position), 32'h0);
        bus.coil = 4'b1010;
        tick(6);
        check("lat_before_step", 32'(bus.step_pulse), 32'h0);
        check("lat_before_pos", 32'(bus.position), 32'h0);
        tick(1);
        check("lat_step", 32'(bus.step_pulse), 32'h1);
        check("lat_pos", 32'(bus.position), 32'h1);
        check("lat_phase", 32'(bus.phase), 32'h1);
        check("lat_dir", 32'(bus.dir_fwd), 32'h1);
        tick(1);
        check("step_one_cycle", 32'(bus.step_pulse), 32'h0);
        tick(12);
        hold(4'b0110, 20);
        hold(4'b0101, 20);
        hold(4'b1001, 20);
        check("fwd_pulses", 32'(pulses - p0), 32'd4);
        check("fwd_pos", 32'(bus.position), 32'h4);
        check("fwd_dir", 32'(bus.dir_fwd), 32'h1);
        check("fwd_phase", 32'(bus.phase), 32'h0);
        check("fwd_moving", 32'(bus.moving), 32'h1);
        check("fwd_errs", 32'({bus.err_illegal, bus.err_skip, bus.err_overrun}), 32'h0);

        // Homing latency
        bus.limit_switches = 2'b01;
        tick(1);
        check("home_sync1", 32'(bus.at_limit), 32'h0);
        tick(1);
        check("home_at_limit", 32'(bus.at_limit), 32'h1);
        check("home_pos_k1", 32'(bus.position), 32'h4);
        tick(1);
        check("home_pos_k2", 32'(bus.position), 32'h0);
        bus.limit_switches = 2'b00;
        tick(5);
        check("home_release", 32'(bus.at_limit), 32'h0);

        // Reverse from 0 wraps
        hold(4'b0101, 20);
        check("rev_pos1", 32'(bus.position), 32'hFFFF);
        hold(4'b0110, 20);
        check("rev_pos2", 32'(bus.position), 32'hFFFE);
        check("rev_dir", 32'(bus.dir_fwd), 32'h0);
        check("rev_phase", 32'(bus.phase), 32'h2);

        // Skip detection
        hold(4'b0101, 20);
        hold(4'b1001, 20);
        check("pre_skip_pos", 32'(bus.position), 32'h0);
        hold(4'b0110, 20);
        check("skip_flag", 32'(bus.err_skip), 32'h1);
        check("skip_pos", 32'(bus.position), 32'h0);
        check("skip_dir", 32'(bus.dir_fwd), 32'h1);
        check("skip_phase", 32'(bus.phase), 32'h2);
        clear_errors();
        check("skip_clr", 32'(bus.err_skip), 32'h0);
        // Skip event coinciding with clr_err: set wins
        bus.coil = 4'b1001;
        tick(6);
        bus.clr_err = 1'b1;
        tick(1);
        check("skip_vs_clr", 32'(bus.err_skip), 32'h1);
        tick(1);
        check("skip_clr2", 32'(bus.err_skip), 32'h0);
        bus.clr_err = 1'b0;
        tick(12);
        check("skip2_phase", 32'(bus.phase), 32'h0);

        // Short glitch rejected, long illegal pattern flagged
        p0 = pulses;
        hold(4'b1111, 2);
        hold(4'b1010, 20);
        check("glitch_no_illegal", 32'(bus.err_illegal), 32'h0);
        check("glitch_pulses", 32'(pulses - p0), 32'd1);
        check("glitch_pos", 32'(bus.position), 32'h1);
        hold(4'b1111, 10);
        check("illegal_flag", 32'(bus.err_illegal), 32'h1);
        check("illegal_phase", 32'(bus.phase), 32'h1);
        check("illegal_pos", 32'(bus.position), 32'h1);

        // Recover, home, then reverse into the home switch
        hold(4'b0110, 20);
        check("recover_pos", 32'(bus.position), 32'h2);
        clear_errors();
        bus.limit_switches = 2'b01;
        tick(5);
        check("home2_pos", 32'(bus.position), 32'h0);
        p0 = pulses;
        hold(4'b1010, 20);
        check("ovr_flag", 32'(bus.err_overrun), 32'h1);
        check("ovr_pos", 32'(bus.position), 32'h0);
        check("ovr_dir", 32'(bus.dir_fwd), 32'h0);
        check("ovr_pulse", 32'(pulses - p0), 32'd1);
        bus.limit_switches = 2'b00;
        clear_errors();
        check("ovr_clr", 32'({bus.err_illegal, bus.err_skip, bus.err_overrun}), 32'h0);
        // Forward step into the max switch
        bus.limit_switches = 2'b10;
        hold(4'b0110, 20);
        check("ovr_max_flag", 32'(bus.err_overrun), 32'h1);
        check("ovr_max_pos", 32'(bus.position), 32'h1);
        bus.limit_switches = 2'b00;
        clear_errors();

        // Idle timeout with slow steps
        tick(60);
        check("idle_moving0", 32'(bus.moving), 32'h0);
        bus.coil = 4'b0101;
        tick(6);
        check("mv_before", 32'(bus.moving), 32'h0);
        tick(1);
        check("mv_set", 32'(bus.moving), 32'h1);
        check("mv_pos", 32'(bus.position), 32'h2);
        tick(49);
        check("mv_last_high", 32'(bus.moving), 32'h1);
        tick(1);
        check("mv_timeout", 32'(bus.moving), 32'h0);
        tick(43);
        bus.coil = 4'b1001;
        tick(7);
        check("mv_set2", 32'(bus.moving), 32'h1);
        check("mv_pos2", 32'(bus.position), 32'h3);
        tick(13);

        // OFF drops moving at the coil latency, then re-acquires without a count
        bus.coil = 4'b0000;
        tick(6);
        check("off_before", 32'(bus.moving), 32'h1);
        tick(1);
        check("off_moving0", 32'(bus.moving), 32'h0);
        tick(13);
        p0 = pulses;
        hold(4'b1010, 20);
        check("reacq_no_step", 32'(pulses - p0), 32'd0);
        check("reacq_pos", 32'(bus.position), 32'h3);
        check("reacq_phase", 32'(bus.phase), 32'h1);
        hold(4'b0110, 20);
        check("reacq_step_pos", 32'(bus.position), 32'h4);

        // Asynchronous reset mid-operation
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_pos", 32'(bus.position), 32'h0);
        check("async_rst_phase", 32'(bus.phase), 32'h0);
        check("async_rst_moving", 32'(bus.moving), 32'h0);
        check("async_rst_dir", 32'(bus.dir_fwd), 32'h0);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
